// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory.
// The loader has priority; a starve counter bounds how long fetch can be denied.
module imem_port_arbiter #(
    parameter int ADDR_BITS    = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_f_req,
    input  logic [31:0]          i_f_addr,
    output logic                 o_f_gnt,
    output logic                 o_f_rvalid,
    output logic [31:0]          o_f_rdata,
    input  logic                 i_l_req,
    input  logic                 i_l_we,
    input  logic [31:0]          i_l_addr,
    input  logic [31:0]          i_l_wdata,
    output logic                 o_l_gnt,
    output logic                 o_l_rvalid,
    output logic [31:0]          o_l_rdata,
    output logic                 o_m_en,
    output logic                 o_m_we,
    output logic [ADDR_BITS-3:0] o_m_addr,
    output logic [31:0]          o_m_wdata,
    input  logic [31:0]          i_m_rdata
);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_nxt;
    logic        r_pend;
    logic        r_owner;
    logic        w_f_gnt;
    logic        w_l_gnt;
    logic [31:0] w_addr;

    always_comb begin
        w_f_gnt      = 1'b0;
        w_l_gnt      = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (i_reset) begin
            w_state_nxt  = ST_NORMAL;
            w_starve_nxt = 4'd0;
        end else begin
            unique case (r_state)
                ST_FORCE: begin
                    w_f_gnt = i_f_req;
                    w_l_gnt = i_l_req & ~i_f_req;
                end
                default: begin
                    w_l_gnt = i_l_req;
                    w_f_gnt = i_f_req & ~i_l_req;
                end
            endcase
            if (i_f_req && !w_f_gnt) begin
                w_starve_nxt = (r_starve >= LIMIT) ? LIMIT : r_starve + 4'd1;
            end else begin
                w_starve_nxt = 4'd0;
            end
            // Fetch is forced on the very cycle after the limit is hit.
            w_state_nxt = (w_starve_nxt == LIMIT) ? ST_FORCE : ST_NORMAL;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_NORMAL;
            r_starve <= 4'd0;
            r_pend   <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_pend   <= w_f_gnt | (w_l_gnt & ~i_l_we);
            r_owner  <= w_l_gnt;
        end
    end

    assign w_addr     = w_l_gnt ? i_l_addr : i_f_addr;

    assign o_f_gnt    = w_f_gnt;
    assign o_l_gnt    = w_l_gnt;
    assign o_m_en     = w_f_gnt | w_l_gnt;
    assign o_m_we     = w_l_gnt & i_l_we;
    assign o_m_addr   = w_addr[ADDR_BITS-1:2];
    assign o_m_wdata  = i_l_wdata;

    // Gating with reset drops a response whose read preceded reset.
    assign o_f_rvalid = r_pend & ~r_owner & ~i_reset;
    assign o_l_rvalid = r_pend & r_owner & ~i_reset;
    assign o_f_rdata  = i_m_rdata;
    assign o_l_rdata  = i_m_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed cases then random traffic
// against a behavioural model of grants, responses and memory contents.
module tb_imem_port_arbiter;

    localparam int AB    = 12;
    localparam int LIMIT = 4;
    localparam int WORDS = 1 << (AB - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;
    logic          l_req;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;
    logic          m_en;
    logic          m_we;
    logic [AB-3:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem       [WORDS];
    logic [31:0] model_mem [WORDS];

    int          denied = 0;
    bit          pend_f = 1'b0;
    bit          pend_l = 1'b0;
    logic [31:0] pend_data = 32'd0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_BITS    (AB),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_f_req    (f_req),
        .i_f_addr   (f_addr),
        .o_f_gnt    (f_gnt),
        .o_f_rvalid (f_rvalid),
        .o_f_rdata  (f_rdata),
        .i_l_req    (l_req),
        .i_l_we     (l_we),
        .i_l_addr   (l_addr),
        .i_l_wdata  (l_wdata),
        .o_l_gnt    (l_gnt),
        .o_l_rvalid (l_rvalid),
        .o_l_rdata  (l_rdata),
        .o_m_en     (m_en),
        .o_m_we     (m_we),
        .o_m_addr   (m_addr),
        .o_m_wdata  (m_wdata),
        .i_m_rdata  (m_rdata)
    );

    // Single-port synchronous memory driven by the DUT's memory port.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rs, input bit fr, input logic [31:0] fa,
                        input bit lr, input bit lwe, input logic [31:0] la,
                        input logic [31:0] lwd);
        bit fg;
        bit lg;
        bit ef;
        bit el;
        int wa;
        @(negedge clk);
        rst     = rs;
        f_req   = fr;
        f_addr  = fa;
        l_req   = lr;
        l_we    = lwe;
        l_addr  = la;
        l_wdata = lwd;
        #1;
        fg = !rs && fr && (!lr || denied >= LIMIT);
        lg = !rs && lr && !fg;
        wa = lg ? int'(la[AB-1:2]) : int'(fa[AB-1:2]);
        check("f_gnt", 32'(f_gnt), 32'(fg));
        check("l_gnt", 32'(l_gnt), 32'(lg));
        check("m_en", 32'(m_en), 32'(fg | lg));
        check("m_we", 32'(m_we), 32'(lg & lwe));
        if (fg || lg) check("m_addr", 32'(m_addr), 32'(wa));
        if (lg && lwe) check("m_wdata", m_wdata, lwd);
        ef = !rs && pend_f;
        el = !rs && pend_l;
        check("f_rvalid", 32'(f_rvalid), 32'(ef));
        check("l_rvalid", 32'(l_rvalid), 32'(el));
        if (ef) check("f_rdata", f_rdata, pend_data);
        if (el) check("l_rdata", l_rdata, pend_data);
        pend_f = fg;
        pend_l = lg && !lwe;
        if (fg || lg) pend_data = model_mem[wa];
        if (lg && lwe) model_mem[wa] = lwd;
        if (!rs && fr && !fg) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
        else                  denied = 0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [6:0] pat;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]       = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
            model_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
        end
        m_rdata = 32'd0;
        rst = 1'b1; f_req = 1'b0; f_addr = 32'd0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;

        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'd0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h8, 32'd0);

        // Fetch-only read
        step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0);
        check("r36_maddr", 32'(m_addr), 32'h4);
        idle();
        check("r36_rvalid", 32'(f_rvalid), 32'h1);

        // Loader write at top word: no response
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF);
        check("r37_maddr", 32'(m_addr), 32'h3FF);
        idle();
        check("r37_norv", 32'({f_rvalid, l_rvalid}), 32'h0);

        // Starvation: loader holds the port until fetch is forced
        pat = '0;
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0000_0FFC, 32'd0);
            pat[c] = f_gnt;
        end
        check("r38_pattern", 32'(pat), 32'h10);
        idle();

        // Alternating readers
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'hC, 32'd0);
        step(1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 32'hC, 32'd0);
        check("r39_frv", 32'({f_rvalid, l_rvalid}), 32'h2);
        idle();
        check("r39_lrv", 32'({f_rvalid, l_rvalid}), 32'h1);

        // Read followed by reset
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'd0, 32'd0);
        check("r40_rv_rst", 32'(f_rvalid), 32'h0);
        step(1'b0, 1'b1, 32'h0001_0013, 1'b0, 1'b0, 32'd0, 32'd0);
        check("r35_first_gnt", 32'(f_gnt), 32'h1);
        check("r40_rv_after", 32'(f_rvalid), 32'h0);
        check("r41_maddr", 32'(m_addr), 32'h4);
        idle();

        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0, $urandom(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom(), $urandom());
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 12: byte-address width of the instruction memory; word address is ADDR_BITS-2 bits.
REQ-002 Parameter STARVE_LIMIT, default 4, range 1..15: maximum consecutive cycles fetch may be denied while requesting.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 f_req  in  1  fetch read request.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_gnt  out  1  fetch request accepted this cycle.
REQ-008 f_rvalid  out  1  fetch read data valid.
REQ-009 f_rdata  out  32  fetch read data.
REQ-010 l_req  in  1  loader/debug request.
REQ-011 l_we  in  1  loader write (1) or read (0).
REQ-012 l_addr  in  32  loader byte address.
REQ-013 l_wdata  in  32  loader write data.
REQ-014 l_gnt  out  1  loader request accepted this cycle.
REQ-015 l_rvalid  out  1  loader read data valid.
REQ-016 l_rdata  out  32  loader read data.
REQ-017 m_en  out  1  memory access enable.
REQ-018 m_we  out  1  memory write enable.
REQ-019 m_addr  out  ADDR_BITS-2  memory word address.
REQ-020 m_wdata  out  32  memory write data.
REQ-021 m_rdata  in  32  memory read data, valid the cycle after a read with m_en=1, m_we=0.

Function
REQ-022 Grants: combinational, same cycle; at most one of f_gnt/l_gnt high; a requester with req=0 is never granted.
REQ-023 Priority: loader wins by default; fetch wins when only f_req is high or when in FORCE_FETCH.
REQ-024 FSM states NORMAL and FORCE_FETCH; NORMAL->FORCE_FETCH when starve counter reaches STARVE_LIMIT; FORCE_FETCH->NORMAL on the cycle fetch is granted.
REQ-025 Starve counter (4 bits): +1 each cycle f_req=1 and f_gnt=0; cleared when f_gnt=1 or f_req=0; saturates at STARVE_LIMIT.
REQ-026 Memory drive: m_en = f_gnt|l_gnt; m_we = l_gnt & l_we; m_addr = granted address bits [ADDR_BITS-1:2]; m_wdata = l_wdata.
REQ-027 Address bits [1:0] and bits at or above ADDR_BITS are ignored (no error, no alignment check).
REQ-028 Response routing: 1-bit registered owner tag plus pending flag; granted read in cycle N gives rvalid to that requester only in cycle N+1.
REQ-029 Loader writes produce no rvalid.
REQ-030 f_rdata = l_rdata = m_rdata (unqualified); consumers qualify with rvalid.
REQ-031 Back-to-back reads by alternating requesters each get exactly one rvalid in order; no bubbles inserted by the arbiter.
REQ-032 FORCE_FETCH with f_req dropped before grant: return to NORMAL next cycle, counter cleared.

Reset
REQ-033 While reset=1: f_gnt=l_gnt=m_en=m_we=0; next state NORMAL, counter 0, pending 0.
REQ-034 Read granted the cycle before reset asserts: its rvalid is suppressed (no rvalid in the cycle after reset).
REQ-035 First grant possible in the first cycle with reset=0.

Verification
REQ-036 f_req=1, f_addr=0x0000_0010, l_req=0 -> f_gnt=1, m_addr=4, m_we=0; next cycle f_rvalid=1, f_rdata=m_rdata.
REQ-037 l_req=1, l_we=1, l_addr=0x0000_0FFC, l_wdata=0xDEADBEEF, f_req=0 -> l_gnt=1, m_we=1, m_addr=0x3FF; no rvalid next cycle.
REQ-038 f_req=1 and l_req=1 held, STARVE_LIMIT=4 -> l_gnt cycles 0-3, f_gnt cycle 4, l_gnt cycle 5, counter 0 after cycle 4.
REQ-039 Alternating reads fetch (addr 0x8), loader (addr 0xC) -> f_rvalid then l_rvalid on consecutive cycles, never both high.
REQ-040 Fetch read granted, reset=1 next cycle -> f_rvalid=0 that cycle and the following cycle; grants 0 during reset.
REQ-041 f_addr=0x0001_0013, ADDR_BITS=12 -> m_addr=0x004.
